// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_pkg
// Description : Shared LDPC decoder definitions. Holds the LLR message width,
//               the symmetric saturation bounds, the message type, the
//               variable-node update state encoding and a clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

    localparam int LLR_W       = 6;
    localparam int LLR_MAX     = (1 << (LLR_W - 1)) - 1;
    localparam int LLR_MIN_SAT = -LLR_MAX;

    typedef logic signed [LLR_W-1:0] llr_t;

    // Variable-node update phases: gather a frame, then emit extrinsics
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } vn_state_t;

    // Ceiling log2; returns 0 for inputs of 0 or 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llr_saturate.sv
`default_nettype none
// ============================================================================
// Module      : llr_saturate
// Description : Combinational symmetric clip of a wide signed value down to
//               an OUT_W-bit message, range [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1].
//               The most negative code is never produced.
// Revision    : 1.0 - initial release
// ============================================================================
module llr_saturate
    import ldpc_pkg::*;
#(
    parameter int IN_W  = LLR_W + 3,
    parameter int OUT_W = LLR_W
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    localparam logic signed [IN_W-1:0] c_max = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] c_min = -c_max;

    // Clip to the symmetric message range, otherwise pass the low bits through
    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        if (i_din > c_max) begin
            o_dout = c_max[OUT_W-1:0];
        end else if (i_din < c_min) begin
            o_dout = c_min[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vn_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : vn_update_unit
// Description : Serial LDPC variable-node update. Accepts a channel LLR plus
//               DV check messages per node, accumulates them at full
//               precision, then emits DV saturated extrinsic messages
//               (total minus each incoming message) with a hard decision.
// Revision    : 1.0 - initial release
// ============================================================================
module vn_update_unit
    import ldpc_pkg::*;
#(
    parameter int LLR_W = 6,
    parameter int DV    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LLR_W-1:0] in_llr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LLR_W-1:0] out_ext,
    output logic             out_hard,
    output logic             out_last
);

    // Accumulator holds DV+1 messages without overflow; the extrinsic
    // difference needs one more bit before it is clipped.
    localparam int ACC_W  = LLR_W + clog2(DV + 1);
    localparam int DIFF_W = ACC_W + 1;
    localparam int BEAT_W = clog2(DV + 1);
    localparam int IDX_W  = clog2(DV);

    localparam logic [BEAT_W-1:0]      c_last_beat    = BEAT_W'(DV);
    localparam logic [IDX_W-1:0]       c_last_idx     = IDX_W'(DV - 1);
    localparam logic signed [LLR_W-1:0] c_llr_most_neg = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic signed [LLR_W-1:0] c_llr_clamp    = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};

    vn_state_t               r_state;
    logic [BEAT_W-1:0]       r_beat;
    logic [IDX_W-1:0]        r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [LLR_W-1:0] r_msg_buf [DV];
    logic                    r_out_valid;
    logic signed [LLR_W-1:0] r_out_ext;
    logic                    r_out_hard;
    logic                    r_out_last;

    logic signed [LLR_W-1:0]  w_in_clamped;
    logic signed [ACC_W-1:0]  w_in_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [IDX_W-1:0]         w_idx_next;
    logic [IDX_W-1:0]         w_rd_idx;
    logic signed [ACC_W-1:0]  w_sub_total;
    logic signed [LLR_W-1:0]  w_sub_msg;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [LLR_W-1:0]  w_sat_ext;

    // The most negative code has no positive counterpart; fold it onto -MAX
    assign w_in_clamped = ($signed(in_llr) == c_llr_most_neg) ? c_llr_clamp : $signed(in_llr);
    assign w_in_ext     = {{(ACC_W-LLR_W){w_in_clamped[LLR_W-1]}}, w_in_clamped};
    assign w_acc_next   = (r_beat == '0) ? w_in_ext : (r_acc + w_in_ext);
    assign w_wr_idx     = IDX_W'(r_beat - BEAT_W'(1));
    assign w_idx_next   = (r_idx == c_last_idx) ? '0 : (r_idx + IDX_W'(1));

    // One subtractor serves both the first message (computed from the total
    // being formed on the final input beat) and every following message.
    assign w_rd_idx    = (r_state == ACCUM) ? '0 : w_idx_next;
    assign w_sub_total = (r_state == ACCUM) ? w_acc_next : r_acc;
    assign w_sub_msg   = r_msg_buf[w_rd_idx];
    assign w_diff      = {w_sub_total[ACC_W-1], w_sub_total}
                       - {{(DIFF_W-LLR_W){w_sub_msg[LLR_W-1]}}, w_sub_msg};

    llr_saturate #(
        .IN_W  (DIFF_W),
        .OUT_W (LLR_W)
    ) u_sat (
        .i_din  (w_diff),
        .o_dout (w_sat_ext)
    );

    // Frame sequencing, message buffering and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_beat      <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            for (int i = 0; i < DV; i++) begin
                r_msg_buf[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_ext   <= '0;
            r_out_hard  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_next;
                        if (r_beat != '0) begin
                            r_msg_buf[w_wr_idx] <= w_in_clamped;
                        end
                        if (r_beat == c_last_beat) begin
                            r_state     <= EMIT;
                            r_beat      <= '0;
                            r_idx       <= '0;
                            r_out_valid <= 1'b1;
                            r_out_ext   <= w_sat_ext;
                            r_out_hard  <= w_acc_next[ACC_W-1];
                            r_out_last  <= 1'b0;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ACCUM;
                            r_beat      <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_next;
                            r_out_ext  <= w_sat_ext;
                            r_out_last <= (w_idx_next == c_last_idx);
                        end
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = r_out_valid;
    assign out_ext   = r_out_ext;
    assign out_hard  = r_out_hard;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_vn_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vn_update_unit
// Description : Directed self-checking bench for vn_update_unit at DV = 3.
//               Expected extrinsics are computed from the inputs and queued
//               when a frame is sent, then popped as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vn_update_unit;

    localparam int LLR_W   = 6;
    localparam int DV      = 3;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic signed [LLR_W-1:0] ext;
        logic                    hard;
        logic                    last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [LLR_W-1:0] in_llr;
    logic             out_valid;
    logic             out_ready;
    logic [LLR_W-1:0] out_ext;
    logic             out_hard;
    logic             out_last;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    vn_update_unit #(
        .LLR_W (LLR_W),
        .DV    (DV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_llr    (in_llr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext),
        .out_hard  (out_hard),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v == -32) ? -31 : v;
    endfunction

    // Reference model: full-precision total, symmetric clip of each extrinsic
    task automatic push_expected(input int a, input int b, input int c, input int d);
        int   m[DV];
        int   total;
        int   e;
        exp_t x;
        m[0]  = clampv(b);
        m[1]  = clampv(c);
        m[2]  = clampv(d);
        total = clampv(a) + m[0] + m[1] + m[2];
        for (int i = 0; i < DV; i++) begin
            e = total - m[i];
            if (e > 31) e = 31;
            else if (e < -31) e = -31;
            x.ext  = LLR_W'(e);
            x.hard = (total < 0);
            x.last = (i == DV - 1);
            sb.push_back(x);
        end
    endtask

    // One input beat, optionally preceded by idle cycles; driven at negedge
    task automatic send_beat(input int v, input int gap);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        in_valid = 1'b1;
        in_llr   = LLR_W'(v);
        while (!in_ready && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d,
                              input int gap);
        push_expected(a, b, c, d);
        send_beat(a, gap);
        check("no_early_valid", out_valid, 0);
        send_beat(b, gap);
        send_beat(c, gap);
        check("no_early_valid", out_valid, 0);
        send_beat(d, gap);
        check("latency_valid", out_valid, 1);
        check("emit_in_ready", in_ready, 0);
    endtask

    // Collect DV messages; stall_k selects a message held for stall_n cycles
    task automatic recv_frame(input int stall_k, input int stall_n);
        exp_t e;
        for (int k = 0; k < DV; k++) begin
            int guard;
            guard     = 0;
            out_ready = 1'b1;
            while (!out_valid && guard < TIMEOUT) begin
                @(negedge clk);
                guard++;
            end
            check("out_valid_wait", out_valid, 1);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    check("hold_ext", $signed(out_ext), e.ext);
                    check("hold_valid", out_valid, 1);
                    check("hold_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            check("ext", $signed(out_ext), e.ext);
            check("hard", out_hard, e.hard);
            check("last", out_last, e.last);
            @(negedge clk);
        end
        check("idle_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ext", $signed(out_ext), 0);
        check("rst_out_hard", out_hard, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_llr    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame
        send_frame(5, 3, -2, 4, 0);
        recv_frame(-1, 0);

        // Positive saturation
        send_frame(31, 31, 31, 31, 0);
        recv_frame(-1, 0);

        // Negative saturation with -32 clamp
        send_frame(-32, -31, -31, -31, 0);
        recv_frame(-1, 0);

        // Reset after two beats; outputs still hold the previous negative frame
        send_beat(5, 0);
        send_beat(3, 0);
        in_valid = 1'b1;
        in_llr   = LLR_W'(7);
        rst_n    = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        check_reset_values();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        send_frame(5, 3, -2, 4, 0);
        recv_frame(-1, 0);

        // Zero total
        send_frame(0, 2, -2, 0, 0);
        recv_frame(-1, 0);

        // Backpressure on the second message
        send_frame(5, 3, -2, 4, 0);
        recv_frame(1, 3);

        // Input bubbles between beats
        send_frame(-7, 20, -15, 9, 2);
        recv_frame(-1, 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
